free_list: RTL
==============

# free_list

Physical-register free list for the rename stage: a circular FIFO of free physical register tags that sits directly upstream of the map table. It supplies one new destination tag per dispatch and reclaims one old tag (T_old) per retiring instruction. It checkpoints its head pointer per ROB entry, so a branch rollback restores the speculative allocation state in a single cycle.

## Interface
- NUM_PR, 64: physical registers; tag width PRW = $clog2(NUM_PR).
- NUM_ARCH, 32: architectural registers; PR 0..NUM_ARCH-1 are mapped at reset and are never initially free.
- NUM_ROB, 8: ROB entries; index width RW = $clog2(NUM_ROB).
- Derived: DEPTH = NUM_PR-NUM_ARCH (32); pointer width PW = $clog2(DEPTH)+1, the MSB being the wrap bit.
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- en  in  1  global stall-release; state updates only when 1 (reset overrides).
- dispatch_en  in  1  consume the head tag this cycle.
- ROB_idx  in  RW  ROB slot of the dispatching instruction; selects the checkpoint written.
- retire_en  in  1  return retire_T_old to the list.
- retire_T_old  in  PRW  tag freed by the retiring instruction.
- rollback_en  in  1  squash and restore head.
- ROB_rollback_idx  in  RW  ROB slot of the oldest squashed instruction.
- free_T_idx  out  PRW  tag at head (combinational from state).
- free_valid  out  1  list non-empty.
- free_count  out  $clog2(DEPTH+1)  number of free tags.

## Operation
- Storage: entries[DEPTH] of PRW bits; head/tail pointers of PW bits; head_ckpt[NUM_ROB] of PW bits.
- free_count = tail - head (PW-bit modular). Empty: head == tail. Full: indices equal and wrap bits differ.
- free_T_idx = entries[head[PW-2:0]]; free_valid = !empty.
- Pop, when dispatch_en && free_valid && !rollback_en:
  - head <= head+1;
  - head_ckpt[ROB_idx] <= head (the pre-pop value).
- dispatch_en while empty: ignored, with no pop and no checkpoint write. Preventing this is the dispatch logic's responsibility.
- Push, when retire_en:
  - entries[tail index] <= retire_T_old; tail <= tail+1.
  - Retire while full is illegal; the push is dropped and a simulation-only assertion fires.
- Rollback, when rollback_en: head <= head_ckpt[ROB_rollback_idx]. Dispatch in the same cycle is ignored.
- Rollback and retire in the same cycle: both apply. The retiring instruction is older than the squash point, so its tail push stands.
- Dispatch and retire in the same cycle: both apply, and count is unchanged. There is no bypass; a tag pushed this cycle is not visible at the head until the next cycle, even when the list was empty.
- Pointer arithmetic wraps modulo 2*DEPTH; the index is the low PW-1 bits.

## Timing
- Reset, on the first rising edge with reset=1:
  - entries[i] = NUM_ARCH+i; head = 0; tail = DEPTH (wrap bit set, i.e. full);
  - head_ckpt all 0.
  - Outputs after reset: free_T_idx = 32, free_valid = 1, free_count = 32.
- Reset asserted mid-operation discards all state, including in-flight rollback requests.
- free_T_idx, free_valid and free_count are combinational from registers. The map table samples free_T_idx in the same cycle dispatch_en is high, and the head advances at that clock edge.
- Rollback latency is 1 cycle: outputs reflect the restored head in the cycle after rollback_en.
- en=0 freezes all registers, including pointers, entries and checkpoints.

## Test plan
- Reset, then 3 dispatches (ROB_idx 0,1,2): free_T_idx reads 32, 33, 34, then 35; free_count is 29.
- Dispatch all 32 tags: free_valid=0 and free_count=0. A further dispatch_en leaves head unchanged. Retire tag 5: the next cycle shows free_T_idx=5 and free_valid=1.
- Dispatch 4 tags (ROB 0..3), then rollback_en with ROB_rollback_idx=2: free_T_idx=34 and free_count=30.
- Rollback with a simultaneous retire of tag 7: head is restored, and tag 7 is present at the tail (free_count = restored count + 1).
- Simultaneous dispatch and retire at steady state over 100 random cycles: free_count is constant, and the tag sequence matches a reference FIFO model, including wrap-around past index 31.
- en=0 with dispatch_en, retire_en and rollback_en all high: no state change. Reset asserted mid-sequence: free_T_idx=32 and free_count=32 on the next cycle.

Source files
------------

// File: rtl/free_list.sv
// Physical-register free list: circular FIFO of free tags with per-ROB head
// checkpoints so a branch squash restores the allocation state in one cycle.
module free_list #(
    parameter int NUM_PR   = 64,
    parameter int NUM_ARCH = 32,
    parameter int NUM_ROB  = 8
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               en,
    input  logic                               dispatch_en,
    input  logic [$clog2(NUM_ROB)-1:0]         ROB_idx,
    input  logic                               retire_en,
    input  logic [$clog2(NUM_PR)-1:0]          retire_T_old,
    input  logic                               rollback_en,
    input  logic [$clog2(NUM_ROB)-1:0]         ROB_rollback_idx,
    output logic [$clog2(NUM_PR)-1:0]          free_T_idx,
    output logic                               free_valid,
    output logic [$clog2(NUM_PR-NUM_ARCH+1)-1:0] free_count
);

    localparam int PRW   = $clog2(NUM_PR);
    localparam int DEPTH = NUM_PR - NUM_ARCH;
    localparam int PW    = $clog2(DEPTH) + 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic [PRW-1:0] entries [DEPTH];
    logic [PW-1:0]  head_ckpt [NUM_ROB];
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic [PW-2:0]  head_idx;
    logic [PW-2:0]  tail_idx;
    logic           empty;
    logic           full;
    logic           pop;
    logic           push;

    assign head_idx = head[PW-2:0];
    assign tail_idx = tail[PW-2:0];
    assign empty    = (head == tail);
    assign full     = (head_idx == tail_idx) && (head[PW-1] != tail[PW-1]);

    // Rollback wins over a same-cycle dispatch; retire is independent of both.
    assign pop  = dispatch_en && !empty && !rollback_en;
    assign push = retire_en && !full;

    assign free_T_idx = entries[head_idx];
    assign free_valid = !empty;
    assign free_count = CW'(tail - head);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= PRW'(NUM_ARCH + i);
            end
            for (int r = 0; r < NUM_ROB; r++) begin
                head_ckpt[r] <= '0;
            end
            head <= '0;
            tail <= PW'(DEPTH);
        end else if (en) begin
            if (rollback_en) begin
                head <= head_ckpt[ROB_rollback_idx];
            end else if (pop) begin
                head               <= head + PW'(1);
                head_ckpt[ROB_idx] <= head;
            end
            if (push) begin
                entries[tail_idx] <= retire_T_old;
                tail              <= tail + PW'(1);
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (!reset && en && retire_en) begin
            assert (!full) else $error("free_list: retire while full, tag dropped");
        end
    end
`endif

endmodule
